itlb: RTL and testbench
=======================

ITLB -- requirements
Module: itlb

Interface
REQ-001 Parameter N_ENTRIES, default 8, number of fully-associative entries (power of two, 2..32).
REQ-002 clk  input  1  clock; reset  input  1  reset, synchronous, active-high.
REQ-003 req_valid  input  1  fetch translation request; accepted when req_valid & req_ready.
REQ-004 req_va  input  64  fetch virtual address.
REQ-005 req_ready  output  1  high only in IDLE with flush low.
REQ-006 flush  input  1  invalidate all entries (sfence.vma / satp write).
REQ-007 rsp_valid  output  1  one-cycle pulse, translation result.
REQ-008 rsp_pa  output  64  {8'd0, ppn[43:0], va[11:0]}.
REQ-009 rsp_fault, rsp_exec  output  1 each  page fault / page executable, qualified by rsp_valid.
REQ-010 walk_req  output  1  one-cycle pulse to page table walker; walk_va  output  64  held stable until walk_rsp_valid.
REQ-011 walk_rsp_valid  input  1  walker done; walk_pa  input  64 (bits 11:0 zero); walk_fault, walk_dirty, walk_exec  input  1 each.

Function
REQ-012 Entry: valid, vpn = va[38:12] (27b), ppn = pa[55:12] (44b), dirty, exec; 4 KB granularity only (walker composes large pages).
REQ-013 States: IDLE, LOOKUP, WALK_REQ, WALK_WAIT, RESP.
REQ-014 IDLE: on accept (cycle T) latch req_va into r_va, go LOOKUP.
REQ-015 LOOKUP (T+1): compare r_va[38:12] against all valid entries; hit -> RESP with hit entry data; miss -> WALK_REQ.
REQ-016 Hit latency: rsp_valid at T+2, registered; then IDLE, req_ready high again at T+3.
REQ-017 WALK_REQ: drive walk_req=1 for exactly one cycle with walk_va=r_va, go WALK_WAIT.
REQ-018 WALK_WAIT: on walk_rsp_valid (cycle W) fill entry if walk_fault=0, then RESP; rsp_valid at W+1 carrying walker data.
REQ-019 Faulting walks never fill; rsp_fault=1, rsp_pa=0, rsp_exec=0.
REQ-020 Non-canonical VA is not checked here; walker reports it as fault.
REQ-021 Victim: lowest-index invalid entry; if all valid, round-robin pointer (log2 N_ENTRIES bits) entry, pointer increments (wraps N_ENTRIES-1 -> 0) on each victim use.
REQ-022 Multiple hits impossible by construction (fill only on miss); no hit arbitration required beyond lowest index.
REQ-023 flush in IDLE: all valid bits cleared next cycle; flush with req_valid same cycle: flush wins, request not accepted.
REQ-024 flush in LOOKUP/WALK_*/RESP: valid bits cleared; in-flight request still completes and returns its result; a walk result arriving after flush (same walk) is returned but not filled.
REQ-025 flush and fill in same cycle: flush wins, entry not written.
REQ-026 walk_rsp_valid outside WALK_WAIT ignored.
REQ-027 rsp_fault, rsp_exec, rsp_pa hold last values between pulses; only rsp_valid qualifies them.

Reset
REQ-028 On reset: state IDLE, all valid bits 0, rr pointer 0, rsp_valid 0, rsp_fault 0, rsp_exec 0, rsp_pa 0, walk_req 0, walk_va 0, r_va 0; req_ready 1 the cycle after reset deasserts.
REQ-029 Reset mid-walk abandons the request; no rsp_valid; a later walk_rsp_valid is ignored (state IDLE).

Structure
REQ-030 Shared package mmu_pkg holds itlb_state_t enum, tlb_entry_t struct, VPN_W=27, PPN_W=44 constants.
REQ-031 One sub-module itlb_cam: combinational match, outputs hit, hit_idx, first_invalid_idx, any_invalid.

Verification
REQ-032 Cold miss: req_va=0x0000_0000_4000_1234, walker returns pa=0x8020_3000 exec=1 -> walk_req once with walk_va equal req_va, rsp_valid at W+1, rsp_pa=0x8020_3234, rsp_exec=1.
REQ-033 Repeat same page va 0x4000_1ff8 -> no walk_req, rsp_valid at T+2, rsp_pa=0x8020_3ff8.
REQ-034 Fault: walker returns walk_fault=1 for va 0x10_0000 -> rsp_fault=1; repeat same va -> second walk_req issued (not cached).
REQ-035 Capacity: 9 distinct pages with N_ENTRIES=8 -> 9th fill evicts entry 0; access to page 1 hits, page 0 misses.
REQ-036 Flush during WALK_WAIT: flush pulse, then walker responds pa=0x9000_0000 -> rsp_pa=0x9000_0xxx returned, next access to same page misses.
REQ-037 Simultaneous flush & req_valid in IDLE -> req_ready=0, request not accepted, all entries invalid next cycle.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared MMU definitions for the instruction TLB.
// Holds the ITLB controller state encoding, the layout of one TLB entry,
// the virtual/physical page number widths (Sv39 VPN, 56-bit PA PPN) and a
// small helper that builds a physical address from a PPN and page offset.
package mmu_pkg;

    localparam int VPN_W = 27;
    localparam int PPN_W = 44;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WALK_REQ,
        WALK_WAIT,
        RESP
    } itlb_state_t;

    typedef struct packed {
        logic             valid;
        logic [VPN_W-1:0] vpn;
        logic [PPN_W-1:0] ppn;
        logic             dirty;
        logic             exec;
    } tlb_entry_t;

    // Physical addresses are 56 bits wide; the top byte is always zero.
    function automatic logic [63:0] compose_pa(input logic [PPN_W-1:0] ppn,
                                               input logic [11:0]      offset);
        return {8'd0, ppn, offset};
    endfunction

endpackage

// File: rtl/itlb_cam.sv
// Fully-associative match array for the ITLB.
// Purely combinational. Compares a lookup VPN against every valid entry and
// reports the lowest matching index, plus the lowest-index free slot used
// for victim selection.
// Ports:
//   valid             per-entry valid bits
//   vpn               per-entry virtual page numbers
//   lookup_vpn        page number being translated
//   hit / hit_idx     a valid entry matched, and which one
//   any_invalid       at least one entry is free
//   first_invalid_idx lowest-index free entry
module itlb_cam
    import mmu_pkg::*;
#(
    parameter  int N_ENTRIES = 8,
    localparam int IDX_W     = $clog2(N_ENTRIES)
) (
    input  logic [N_ENTRIES-1:0] valid,
    input  logic [VPN_W-1:0]     vpn [N_ENTRIES],
    input  logic [VPN_W-1:0]     lookup_vpn,
    output logic                 hit,
    output logic [IDX_W-1:0]     hit_idx,
    output logic                 any_invalid,
    output logic [IDX_W-1:0]     first_invalid_idx
);

    // Walking from the top index down lets the lowest index win both searches.
    always_comb begin
        hit               = 1'b0;
        hit_idx           = '0;
        any_invalid       = 1'b0;
        first_invalid_idx = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && (vpn[i] == lookup_vpn)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid[i]) begin
                any_invalid       = 1'b1;
                first_invalid_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/itlb.sv
// Instruction TLB: fully-associative, 4 KB pages, one request in flight.
// A fetch request is latched, looked up in the CAM the next cycle, and either
// answered from the hit entry or sent to the page table walker. Successful
// walks are cached; faulting walks never are. flush invalidates every entry
// but never cancels the request already in flight.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   req_valid, req_va, req_ready       fetch translation request handshake
//   flush                              invalidate all entries
//   rsp_valid, rsp_pa, rsp_fault,
//   rsp_exec                           translation result (pulse + held data)
//   walk_req, walk_va                  walker request (pulse + held address)
//   walk_rsp_valid, walk_pa,
//   walk_fault, walk_dirty, walk_exec  walker result
module itlb
    import mmu_pkg::*;
#(
    parameter int N_ENTRIES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [63:0] req_va,
    output logic        req_ready,
    input  logic        flush,
    output logic        rsp_valid,
    output logic [63:0] rsp_pa,
    output logic        rsp_fault,
    output logic        rsp_exec,
    output logic        walk_req,
    output logic [63:0] walk_va,
    input  logic        walk_rsp_valid,
    input  logic [63:0] walk_pa,
    input  logic        walk_fault,
    input  logic        walk_dirty,
    input  logic        walk_exec
);

    localparam int IDX_W = $clog2(N_ENTRIES);

    itlb_state_t      state;
    logic [63:0]      r_va;
    logic [IDX_W-1:0] rr_ptr;
    logic             flushed;
    tlb_entry_t       entries [N_ENTRIES];

    logic [N_ENTRIES-1:0] valid_vec;
    logic [N_ENTRIES-1:0] dirty_vec;
    logic [VPN_W-1:0]     vpn_arr [N_ENTRIES];

    logic             cam_hit;
    logic [IDX_W-1:0] cam_hit_idx;
    logic             cam_any_invalid;
    logic [IDX_W-1:0] cam_first_invalid;
    logic [IDX_W-1:0] victim_idx;
    logic             fill_ok;

    // The dirty bit is kept for the entry format but fetch never consumes it,
    // and the walker's page-offset and top-byte bits carry no information.
    logic unused_bits;
    assign unused_bits = ^{walk_pa[63:56], walk_pa[11:0], dirty_vec};

    assign req_ready = (state == IDLE) && !flush;

    always_comb begin
        valid_vec = '0;
        dirty_vec = '0;
        vpn_arr   = '{default: '0};
        for (int i = 0; i < N_ENTRIES; i++) begin
            valid_vec[i] = entries[i].valid;
            dirty_vec[i] = entries[i].dirty;
            vpn_arr[i]   = entries[i].vpn;
        end
    end

    itlb_cam #(
        .N_ENTRIES(N_ENTRIES)
    ) u_cam (
        .valid            (valid_vec),
        .vpn              (vpn_arr),
        .lookup_vpn       (r_va[38:12]),
        .hit              (cam_hit),
        .hit_idx          (cam_hit_idx),
        .any_invalid      (cam_any_invalid),
        .first_invalid_idx(cam_first_invalid)
    );

    // Free slots are used first; only a full TLB consumes the round-robin pointer.
    assign victim_idx = cam_any_invalid ? cam_first_invalid : rr_ptr;

    // A walk that overlapped a flush may describe a stale mapping, so it is
    // returned to the fetch unit but never cached.
    assign fill_ok = !walk_fault && !flush && !flushed;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            r_va      <= '0;
            rr_ptr    <= '0;
            flushed   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_pa    <= '0;
            rsp_fault <= 1'b0;
            rsp_exec  <= 1'b0;
            walk_req  <= 1'b0;
            walk_va   <= '0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid && !flush) begin
                        r_va    <= req_va;
                        flushed <= 1'b0;
                        state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (cam_hit) begin
                        rsp_valid <= 1'b1;
                        rsp_pa    <= compose_pa(entries[cam_hit_idx].ppn, r_va[11:0]);
                        rsp_fault <= 1'b0;
                        rsp_exec  <= entries[cam_hit_idx].exec;
                        state     <= RESP;
                    end else begin
                        walk_req <= 1'b1;
                        walk_va  <= r_va;
                        state    <= WALK_REQ;
                    end
                end
                WALK_REQ: begin
                    walk_req <= 1'b0;
                    state    <= WALK_WAIT;
                end
                WALK_WAIT: begin
                    if (walk_rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_fault <= walk_fault;
                        rsp_exec  <= walk_fault ? 1'b0 : walk_exec;
                        rsp_pa    <= walk_fault ? '0
                                                : compose_pa(walk_pa[55:12], r_va[11:0]);
                        if (fill_ok) begin
                            entries[victim_idx] <= '{valid: 1'b1,
                                                     vpn:   r_va[38:12],
                                                     ppn:   walk_pa[55:12],
                                                     dirty: walk_dirty,
                                                     exec:  walk_exec};
                            if (!cam_any_invalid) begin
                                rr_ptr <= rr_ptr + IDX_W'(1);
                            end
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Placed after the state machine so an invalidation overrides any
            // fill scheduled in the same cycle.
            if (flush) begin
                flushed <= 1'b1;
                for (int i = 0; i < N_ENTRIES; i++) begin
                    entries[i].valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_itlb.sv
// Self-checking bench for the ITLB.
// The driver predicts each response from a behavioural TLB model and a fixed
// page table, pushing it into a scoreboard queue; a monitor pops and compares
// whenever rsp_valid fires. A walker process answers walk requests from the
// same page table after a random delay.
module tb_itlb;
    import mmu_pkg::*;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [63:0] req_va = '0;
    logic        req_ready;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic [63:0] rsp_pa;
    logic        rsp_fault;
    logic        rsp_exec;
    logic        walk_req;
    logic [63:0] walk_va;
    logic        walk_rsp_valid = 1'b0;
    logic [63:0] walk_pa = '0;
    logic        walk_fault = 1'b0;
    logic        walk_dirty = 1'b0;
    logic        walk_exec = 1'b0;

    itlb #(.N_ENTRIES(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_va        (req_va),
        .req_ready     (req_ready),
        .flush         (flush),
        .rsp_valid     (rsp_valid),
        .rsp_pa        (rsp_pa),
        .rsp_fault     (rsp_fault),
        .rsp_exec      (rsp_exec),
        .walk_req      (walk_req),
        .walk_va       (walk_va),
        .walk_rsp_valid(walk_rsp_valid),
        .walk_pa       (walk_pa),
        .walk_fault    (walk_fault),
        .walk_dirty    (walk_dirty),
        .walk_exec     (walk_exec)
    );

    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    int checks = 0;
    int errors = 0;
    int reset_epoch = 0;

    function automatic void checkOutput(input string name, input logic [63:0] act,
                                        input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle_cnt);
        end
    endfunction

    function automatic void failNow(input string name, input string why);
        checks++;
        errors++;
        $display("[TB] FAIL %s: %s (cycle %0d)", name, why, cycle_cnt);
    endfunction

    // Page table seen by the walker: fixed per page once created.
    logic [43:0] pt_ppn   [bit [26:0]];
    bit          pt_fault [bit [26:0]];
    bit          pt_exec  [bit [26:0]];

    function automatic void ptSet(input bit [26:0] vpn, input logic [43:0] ppn,
                                  input bit fault, input bit exec);
        pt_ppn[vpn]   = ppn;
        pt_fault[vpn] = fault;
        pt_exec[vpn]  = exec;
    endfunction

    function automatic void ptEnsure(input bit [26:0] vpn);
        logic [63:0] r;
        if (!pt_ppn.exists(vpn)) begin
            r = {$urandom(), $urandom()};
            ptSet(vpn, r[43:0], ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end
    endfunction

    // Reference TLB contents: slot array plus replacement pointer.
    bit          m_valid [N];
    bit [26:0]   m_vpn   [N];
    logic [43:0] m_ppn   [N];
    bit          m_exec  [N];
    int          m_rr = 0;

    function automatic int modelLookup(input bit [26:0] vpn);
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && m_vpn[i] == vpn) return i;
        end
        return -1;
    endfunction

    function automatic void modelFlush();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic void modelReset();
        modelFlush();
        m_rr = 0;
    endfunction

    function automatic void modelFill(input bit [26:0] vpn, input logic [43:0] ppn, input bit exec);
        int slot;
        slot = -1;
        for (int i = 0; i < N; i++) begin
            if (!m_valid[i] && slot < 0) slot = i;
        end
        if (slot < 0) begin
            slot = m_rr;
            m_rr = (m_rr + 1) % N;
        end
        m_valid[slot] = 1'b1;
        m_vpn[slot]   = vpn;
        m_ppn[slot]   = ppn;
        m_exec[slot]  = exec;
    endfunction

    typedef struct {
        logic [63:0] pa;
        logic        fault;
        logic        exec;
        bit          hit;
        int          acc_cycle;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] walk_exp_q[$];
    int          walk_rsp_cycle = 0;
    exp_t        mon_e;

    // Response monitor: every rsp_valid pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (exp_q.size() == 0) begin
                failNow("unexpected_rsp", $sformatf("rsp_valid with pa 0x%0h, nothing outstanding", rsp_pa));
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("rsp_pa", rsp_pa, mon_e.pa);
                checkOutput("rsp_fault", 64'(rsp_fault), 64'(mon_e.fault));
                checkOutput("rsp_exec", 64'(rsp_exec), 64'(mon_e.exec));
                if (mon_e.hit)
                    checkOutput("hit_latency", 64'(cycle_cnt - mon_e.acc_cycle), 64'd2);
                else
                    checkOutput("miss_latency", 64'(cycle_cnt - walk_rsp_cycle), 64'd1);
            end
        end
    end

    // Page table walker model.
    initial begin : walker
        logic [63:0] va;
        logic [63:0] r;
        bit [26:0]   vpn;
        int          d;
        int          epoch;
        forever begin
            @(negedge clk);
            if (!reset && walk_req) begin
                va    = walk_va;
                epoch = reset_epoch;
                if (walk_exp_q.size() == 0)
                    failNow("unexpected_walk", $sformatf("walk_req for va 0x%0h", va));
                else
                    checkOutput("walk_va", va, walk_exp_q.pop_front());
                vpn = va[38:12];
                ptEnsure(vpn);
                d = $urandom_range(1, 4);
                repeat (d) @(posedge clk);
                #1;
                if (epoch == reset_epoch) checkOutput("walk_va_hold", walk_va, va);
                r              = {$urandom(), $urandom()};
                walk_pa        = {r[63:56], pt_ppn[vpn], 12'h000};
                walk_fault     = pt_fault[vpn];
                walk_exec      = pt_exec[vpn];
                walk_dirty     = r[0];
                walk_rsp_valid = 1'b1;
                walk_rsp_cycle = cycle_cnt;
                @(posedge clk);
                #1;
                walk_rsp_valid = 1'b0;
            end
        end
    end

    task automatic waitReady(output bit ok);
        int guard;
        guard = 0;
        @(posedge clk);
        #1;
        while (!req_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        ok = req_ready;
        if (!ok) failNow("ready_timeout", "req_ready stayed low for 50 cycles");
    endtask

    // One complete translation: predict, issue, optionally flush mid-walk, await response.
    task automatic applyStimulus(input logic [63:0] va, input bit flush_mid);
        exp_t      e;
        bit [26:0] vpn;
        int        idx;
        int        guard;
        bit        ok;
        bit        flushed;
        vpn = va[38:12];
        ptEnsure(vpn);
        waitReady(ok);
        if (!ok) return;
        idx   = modelLookup(vpn);
        e.hit = (idx >= 0);
        if (e.hit) begin
            e.pa    = {8'h00, m_ppn[idx], va[11:0]};
            e.fault = 1'b0;
            e.exec  = m_exec[idx];
        end else begin
            e.fault = pt_fault[vpn];
            e.exec  = pt_fault[vpn] ? 1'b0 : pt_exec[vpn];
            e.pa    = pt_fault[vpn] ? 64'h0 : {8'h00, pt_ppn[vpn], va[11:0]};
            walk_exp_q.push_back(va);
        end
        e.acc_cycle = cycle_cnt;
        exp_q.push_back(e);
        req_valid = 1'b1;
        req_va    = va;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_va    = {$urandom(), $urandom()};
        flushed   = 1'b0;
        if (!e.hit && flush_mid) begin
            guard = 0;
            while (walk_exp_q.size() != 0 && guard < 20) begin
                @(posedge clk);
                #1;
                guard++;
            end
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
            modelFlush();
            flushed = 1'b1;
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (exp_q.size() != 0) begin
            failNow("rsp_timeout", $sformatf("no response for va 0x%0h", va));
            exp_q.delete();
            walk_exp_q.delete();
        end else begin
            checkOutput("req_ready_after_rsp", 64'(req_ready), 64'd1);
            checkOutput("rsp_pa_hold", rsp_pa, e.pa);
        end
        if (!e.hit && !e.fault && !flushed) modelFill(vpn, pt_ppn[vpn], pt_exec[vpn]);
    endtask

    task automatic plainFlush();
        bit ok;
        waitReady(ok);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        modelFlush();
    endtask

    // flush and a request in the same idle cycle: request must be refused.
    task automatic flushWithReq(input logic [63:0] va);
        bit ok;
        waitReady(ok);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_va    = va;
        #1;
        checkOutput("req_ready_during_flush", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        modelFlush();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("req_ready_after_flush", 64'(req_ready), 64'd1);
    endtask

    task automatic doReset(input int cycles);
        reset = 1'b1;
        reset_epoch++;
        repeat (cycles) @(posedge clk);
        #1;
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset_rsp_pa", rsp_pa, 64'd0);
        checkOutput("reset_rsp_fault", 64'(rsp_fault), 64'd0);
        checkOutput("reset_rsp_exec", 64'(rsp_exec), 64'd0);
        checkOutput("reset_walk_req", 64'(walk_req), 64'd0);
        checkOutput("reset_walk_va", walk_va, 64'd0);
        exp_q.delete();
        walk_exp_q.delete();
        modelReset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("req_ready_after_reset", 64'(req_ready), 64'd1);
    endtask

    initial begin : stimulus
        bit [26:0]   pool [12];
        logic [63:0] va;
        int          r;
        bit          ok;

        ptSet(27'h40001, 44'h80203, 1'b0, 1'b1);
        ptSet(27'h00100, 44'h0abcd, 1'b1, 1'b1);
        ptSet(27'h77777, 44'h90000, 1'b0, 1'b0);
        ptSet(27'h55555, 44'h12345, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) ptSet(27'h20000 + 27'(i), 44'h100 + 44'(i), 1'b0, i[0]);

        doReset(3);

        // Cold miss, then a hit on the same page.
        applyStimulus(64'h0000_0000_4000_1234, 1'b0);
        applyStimulus(64'h0000_0000_4000_1ff8, 1'b0);

        // Faulting walk is never cached: both accesses walk.
        applyStimulus(64'h0000_0000_0010_0000, 1'b0);
        applyStimulus(64'h0000_0000_0010_0000, 1'b0);

        // Simultaneous flush and request, then the cached page must miss.
        flushWithReq(64'h0000_0000_4000_1234);
        applyStimulus(64'h0000_0000_4000_1234, 1'b0);

        // Capacity: nine pages into eight entries evicts entry 0.
        plainFlush();
        for (int i = 0; i < 9; i++) applyStimulus(64'h2000_0000 + 64'(i) * 64'h1000 + 64'h40, 1'b0);
        applyStimulus(64'h0000_0000_2000_1008, 1'b0);
        applyStimulus(64'h0000_0000_2000_0010, 1'b0);

        // Flush during the walk: result returned but not cached.
        applyStimulus(64'h0000_0000_7777_7abc, 1'b1);
        applyStimulus(64'h0000_0000_7777_7abc, 1'b0);

        // Randomized traffic over a small page pool.
        foreach (pool[i]) pool[i] = 27'($urandom());
        for (int n = 0; n < 150; n++) begin
            r  = $urandom_range(0, 99);
            va = {25'd0, pool[$urandom_range(0, 11)], 12'($urandom())};
            if (r < 4) flushWithReq(va);
            else       applyStimulus(va, (r < 14));
        end

        // Reset in the middle of a walk abandons the request.
        plainFlush();
        waitReady(ok);
        walk_exp_q.push_back(64'h0000_0000_5555_5000);
        req_valid = 1'b1;
        req_va    = 64'h0000_0000_5555_5000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        doReset(2);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("idle_after_abandon", 64'(req_ready), 64'd1);
        applyStimulus(64'h0000_0000_5555_5008, 1'b0);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
